ddr3_init_seq: RTL and testbench

// - Power-up/initialisation sequencer for the DDR3 DFI PHY: drives the JEDEC reset/CKE/MRS/ZQCL sequence onto the DFI command bus.
// - Loads the PHY read/write latencies over the cfg port, then asserts done_o.
// - Owns the DFI command bus until done_o is high. A downstream mux then hands the bus to the memory controller.

---
 rtl/ddr3_init_seq_pkg.sv | 89 ++++++++
 rtl/ddr3_init_seq.sv | 180 ++++++++++++++++++
 tb/tb_ddr3_init_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_init_seq_pkg.sv
// Shared types, command encodings and mode-register field helpers for the
// DDR3 power-up/initialisation sequencer.
package ddr3_init_seq_pkg;

  localparam int unsigned TMR_W = 16;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_CKE  = 4'd1,
    ST_XPR  = 4'd2,
    ST_MR2  = 4'd3,
    ST_MR3  = 4'd4,
    ST_MR1  = 4'd5,
    ST_MR0  = 4'd6,
    ST_ZQ   = 4'd7,
    ST_CFG  = 4'd8,
    ST_DONE = 4'd9
  } state_e;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } dfi_cmd_t;

  localparam dfi_cmd_t CMD_DESEL = dfi_cmd_t'(4'b1111);
  localparam dfi_cmd_t CMD_NOP   = dfi_cmd_t'(4'b0111);
  localparam dfi_cmd_t CMD_MRS   = dfi_cmd_t'(4'b0000);
  localparam dfi_cmd_t CMD_ZQCL  = dfi_cmd_t'(4'b0110);

  localparam int unsigned MR0_CL_LSB      = 4;
  localparam int unsigned MR0_DLL_RST_BIT = 8;
  localparam int unsigned MR0_WR_LSB      = 9;
  localparam int unsigned MR1_DLL_DIS_BIT = 0;
  localparam int unsigned MR2_CWL_LSB     = 3;
  localparam int unsigned ZQ_A10_BIT      = 10;
  localparam int unsigned CFG_CL_LSB      = 8;
  localparam int unsigned CFG_CWL_LSB     = 12;
  localparam logic [2:0]  MR0_WR6         = 3'b010;

  function automatic logic [15:0] mr0_val(input logic [3:0] cl, input logic dll_off);
    logic [15:0] v;
    v = '0;
    v[MR0_CL_LSB +: 3]   = 3'(cl - 4'd4);
    v[MR0_DLL_RST_BIT]   = ~dll_off;
    v[MR0_WR_LSB +: 3]   = MR0_WR6;
    return v;
  endfunction

  function automatic logic [15:0] mr1_val(input logic dll_off);
    logic [15:0] v;
    v = '0;
    v[MR1_DLL_DIS_BIT] = dll_off;
    return v;
  endfunction

  function automatic logic [15:0] mr2_val(input logic [3:0] cwl);
    logic [15:0] v;
    v = '0;
    v[MR2_CWL_LSB +: 3] = 3'(cwl - 4'd5);
    return v;
  endfunction

  function automatic logic [31:0] cfg_val(input logic [3:0] cl, input logic [3:0] cwl);
    logic [31:0] v;
    v = '0;
    v[CFG_CL_LSB  +: 4] = cl - 4'd2;
    v[CFG_CWL_LSB +: 4] = cwl - 4'd2;
    return v;
  endfunction

  // Fixed JEDEC ordering; ST_DONE only leaves on an explicit re-init request.
  function automatic state_e next_of(input state_e s);
    case (s)
      ST_RST:  return ST_CKE;
      ST_CKE:  return ST_XPR;
      ST_XPR:  return ST_MR2;
      ST_MR2:  return ST_MR3;
      ST_MR3:  return ST_MR1;
      ST_MR1:  return ST_MR0;
      ST_MR0:  return ST_ZQ;
      ST_ZQ:   return ST_CFG;
      ST_CFG:  return ST_DONE;
      default: return ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/ddr3_init_seq.sv
// DDR3 DFI power-up sequencer: RESET#/CKE/MRS/ZQCL, then PHY latency config
// and bus hand-off via done_o.
module ddr3_init_seq
  import ddr3_init_seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 14,
  parameter int unsigned DEFAULT_CL  = 6,
  parameter int unsigned DEFAULT_CWL = 6,
  parameter int unsigned DLL_OFF     = 1,
  parameter int unsigned T_RST       = 20000,
  parameter int unsigned T_CKE       = 50000,
  parameter int unsigned T_XPR       = 28,
  parameter int unsigned T_MRD       = 4,
  parameter int unsigned T_MOD       = 12,
  parameter int unsigned T_ZQINIT    = 512
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 init_req_i,
  output logic                 done_o,
  output logic                 cfg_valid_o,
  output logic [31:0]          cfg_data_o,
  output logic                 dfi_reset_n_o,
  output logic                 dfi_cke_o,
  output logic                 dfi_cs_n_o,
  output logic                 dfi_ras_n_o,
  output logic                 dfi_cas_n_o,
  output logic                 dfi_we_n_o,
  output logic                 dfi_odt_o,
  output logic [2:0]           dfi_bank_o,
  output logic [ADDR_BITS-1:0] dfi_addr_o
);

  if (DEFAULT_CL < 5 || DEFAULT_CL > 11) begin : g_bad_cl
    $error("ddr3_init_seq: DEFAULT_CL out of range 5..11");
  end
  if (DEFAULT_CWL < 5 || DEFAULT_CWL > 8) begin : g_bad_cwl
    $error("ddr3_init_seq: DEFAULT_CWL out of range 5..8");
  end
  if (ADDR_BITS < 12 || ADDR_BITS > 16) begin : g_bad_addr
    $error("ddr3_init_seq: ADDR_BITS out of range 12..16");
  end
  if (T_RST < 1 || T_CKE < 1 || T_XPR < 1 || T_MRD < 1 || T_MOD < 1 || T_ZQINIT < 1 ||
      T_RST > 65536 || T_CKE > 65536 || T_XPR > 65536 || T_MRD > 65536 ||
      T_MOD > 65536 || T_ZQINIT > 65536) begin : g_bad_timing
    $error("ddr3_init_seq: timing parameters must be 1..65536");
  end

  localparam logic                 DLL_DIS  = (DLL_OFF != 0);
  localparam logic [ADDR_BITS-1:0] MR0_A    = ADDR_BITS'(mr0_val(4'(DEFAULT_CL), DLL_DIS));
  localparam logic [ADDR_BITS-1:0] MR1_A    = ADDR_BITS'(mr1_val(DLL_DIS));
  localparam logic [ADDR_BITS-1:0] MR2_A    = ADDR_BITS'(mr2_val(4'(DEFAULT_CWL)));
  localparam logic [ADDR_BITS-1:0] ZQ_A     = ADDR_BITS'(1) << ZQ_A10_BIT;
  localparam logic [31:0]          CFG_WORD = cfg_val(4'(DEFAULT_CL), 4'(DEFAULT_CWL));

  // Timer reload value (duration - 1) for the state being entered.
  function automatic logic [TMR_W-1:0] reload(input state_e s);
    case (s)
      ST_RST:                  return TMR_W'(T_RST - 1);
      ST_CKE:                  return TMR_W'(T_CKE - 1);
      ST_XPR:                  return TMR_W'(T_XPR - 1);
      ST_MR2, ST_MR3, ST_MR1:  return TMR_W'(T_MRD - 1);
      ST_MR0:                  return TMR_W'(T_MOD - 1);
      ST_ZQ:                   return TMR_W'(T_ZQINIT - 1);
      default:                 return '0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             entry;

  logic                 dfi_reset_n_q, dfi_reset_n_d;
  logic                 dfi_cke_q, dfi_cke_d;
  dfi_cmd_t             cmd_q, cmd_d;
  logic [2:0]           bank_q, bank_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic [31:0]          cfg_data_q, cfg_data_d;
  logic                 done_q, done_d;

  // State and timer register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_RST;
      timer_q <= reload(ST_RST);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state and timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q == ST_DONE) begin
      if (init_req_i) state_d = ST_RST;
    end else if (timer_q == '0) begin
      state_d = next_of(state_q);
    end
    if (state_d != state_q) begin
      timer_d = reload(state_d);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TMR_W'(1);
    end
  end

  // Outputs for the state about to be occupied; commands fire on its first cycle.
  always_comb begin
    dfi_reset_n_d = 1'b1;
    dfi_cke_d     = 1'b1;
    cmd_d         = CMD_NOP;
    bank_d        = '0;
    addr_d        = '0;
    cfg_valid_d   = 1'b0;
    cfg_data_d    = '0;
    done_d        = 1'b0;
    entry         = (state_d != state_q);
    case (state_d)
      ST_RST: begin
        dfi_reset_n_d = 1'b0;
        dfi_cke_d     = 1'b0;
        cmd_d         = CMD_DESEL;
      end
      ST_CKE: begin
        dfi_cke_d = 1'b0;
        cmd_d     = CMD_DESEL;
      end
      ST_MR2: if (entry) begin cmd_d = CMD_MRS; bank_d = 3'd2; addr_d = MR2_A; end
      ST_MR3: if (entry) begin cmd_d = CMD_MRS; bank_d = 3'd3; addr_d = '0;    end
      ST_MR1: if (entry) begin cmd_d = CMD_MRS; bank_d = 3'd1; addr_d = MR1_A; end
      ST_MR0: if (entry) begin cmd_d = CMD_MRS; bank_d = 3'd0; addr_d = MR0_A; end
      ST_ZQ:  if (entry) begin cmd_d = CMD_ZQCL; addr_d = ZQ_A; end
      ST_CFG: begin
        cfg_valid_d = 1'b1;
        cfg_data_d  = CFG_WORD;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dfi_reset_n_q <= 1'b0;
      dfi_cke_q     <= 1'b0;
      cmd_q         <= CMD_DESEL;
      bank_q        <= '0;
      addr_q        <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_data_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      dfi_reset_n_q <= dfi_reset_n_d;
      dfi_cke_q     <= dfi_cke_d;
      cmd_q         <= cmd_d;
      bank_q        <= bank_d;
      addr_q        <= addr_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_data_q    <= cfg_data_d;
      done_q        <= done_d;
    end
  end

  assign done_o        = done_q;
  assign cfg_valid_o   = cfg_valid_q;
  assign cfg_data_o    = cfg_data_q;
  assign dfi_reset_n_o = dfi_reset_n_q;
  assign dfi_cke_o     = dfi_cke_q;
  assign dfi_cs_n_o    = cmd_q.cs_n;
  assign dfi_ras_n_o   = cmd_q.ras_n;
  assign dfi_cas_n_o   = cmd_q.cas_n;
  assign dfi_we_n_o    = cmd_q.we_n;
  assign dfi_odt_o     = 1'b0;
  assign dfi_bank_o    = bank_q;
  assign dfi_addr_o    = addr_q;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Directed table-driven bench for ddr3_init_seq with shortened timings;
// a second instance covers DLL-on, CL=8, CWL=7 mode-register values.
module tb_ddr3_init_seq;

  localparam int unsigned AB = 14;

  logic          clock;
  logic          reset_n;
  logic          init_req;

  logic          done1, cv1, rst1, cke1, cs1, ras1, cas1, we1, odt1;
  logic [31:0]   cd1;
  logic [2:0]    bank1;
  logic [AB-1:0] addr1;

  logic          done2, cv2, rst2, cke2, cs2, ras2, cas2, we2, odt2;
  logic [31:0]   cd2;
  logic [2:0]    bank2;
  logic [AB-1:0] addr2;

  int n_vec  = 0;
  int n_miss = 0;

  ddr3_init_seq #(
    .ADDR_BITS(AB), .DEFAULT_CL(6), .DEFAULT_CWL(6), .DLL_OFF(1),
    .T_RST(8), .T_CKE(10), .T_XPR(5), .T_MRD(4), .T_MOD(6), .T_ZQINIT(16)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .init_req_i(init_req),
    .done_o(done1), .cfg_valid_o(cv1), .cfg_data_o(cd1),
    .dfi_reset_n_o(rst1), .dfi_cke_o(cke1), .dfi_cs_n_o(cs1), .dfi_ras_n_o(ras1),
    .dfi_cas_n_o(cas1), .dfi_we_n_o(we1), .dfi_odt_o(odt1),
    .dfi_bank_o(bank1), .dfi_addr_o(addr1)
  );

  ddr3_init_seq #(
    .ADDR_BITS(AB), .DEFAULT_CL(8), .DEFAULT_CWL(7), .DLL_OFF(0),
    .T_RST(8), .T_CKE(10), .T_XPR(5), .T_MRD(4), .T_MOD(6), .T_ZQINIT(16)
  ) u_dut2 (
    .clock(clock), .reset_n(reset_n), .init_req_i(init_req),
    .done_o(done2), .cfg_valid_o(cv2), .cfg_data_o(cd2),
    .dfi_reset_n_o(rst2), .dfi_cke_o(cke2), .dfi_cs_n_o(cs2), .dfi_ras_n_o(ras2),
    .dfi_cas_n_o(cas2), .dfi_we_n_o(we2), .dfi_odt_o(odt2),
    .dfi_bank_o(bank2), .dfi_addr_o(addr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        init;
    logic        rst;
    logic        cke;
    logic [3:0]  cmd;
    logic [2:0]  bank;
    logic [13:0] addr;
    logic        cv;
    logic [31:0] cd;
    logic        done;
    logic [13:0] addr2;
    logic [31:0] cd2;
  } vec_t;

  vec_t rows[$];

  task automatic add(input int cyc, input logic init, input logic rst, input logic cke,
                     input logic [3:0] cmd, input logic [2:0] bank, input logic [13:0] addr,
                     input logic cv, input logic [31:0] cd, input logic done,
                     input logic [13:0] a2, input logic [31:0] c2);
    vec_t v;
    v.cyc = cyc; v.init = init; v.rst = rst; v.cke = cke; v.cmd = cmd; v.bank = bank;
    v.addr = addr; v.cv = cv; v.cd = cd; v.done = done; v.addr2 = a2; v.cd2 = c2;
    rows.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_row(input vec_t v);
    chk("reset_n", v.cyc, 32'(rst1), 32'(v.rst));
    chk("cke",     v.cyc, 32'(cke1), 32'(v.cke));
    chk("cmd",     v.cyc, 32'({cs1, ras1, cas1, we1}), 32'(v.cmd));
    chk("bank",    v.cyc, 32'(bank1), 32'(v.bank));
    chk("addr",    v.cyc, 32'(addr1), 32'(v.addr));
    chk("odt",     v.cyc, 32'(odt1), 32'd0);
    chk("cfg_v",   v.cyc, 32'(cv1), 32'(v.cv));
    chk("cfg_d",   v.cyc, cd1, v.cd);
    chk("done",    v.cyc, 32'(done1), 32'(v.done));
    chk("cmd2",    v.cyc, 32'({cs2, ras2, cas2, we2}), 32'(v.cmd));
    chk("addr2",   v.cyc, 32'(addr2), 32'(v.addr2));
    chk("cfg_d2",  v.cyc, cd2, v.cd2);
  endtask

  task automatic chk_reset_vals(input string tag, input int cyc);
    chk({tag, "_rst"},  cyc, 32'(rst1), 32'd0);
    chk({tag, "_cke"},  cyc, 32'(cke1), 32'd0);
    chk({tag, "_cmd"},  cyc, 32'({cs1, ras1, cas1, we1}), 32'hF);
    chk({tag, "_bank"}, cyc, 32'(bank1), 32'd0);
    chk({tag, "_addr"}, cyc, 32'(addr1), 32'd0);
    chk({tag, "_cv"},   cyc, 32'(cv1), 32'd0);
    chk({tag, "_cd"},   cyc, cd1, 32'd0);
    chk({tag, "_done"}, cyc, 32'(done1), 32'd0);
    chk({tag, "_done2"}, cyc, 32'(done2), 32'd0);
  endtask

  localparam logic [3:0] DS = 4'hF, NP = 4'h7, MR = 4'h0, ZQ = 4'h6;

  initial begin
    int ri;
    int k;
    int pulses;
    bit seen;

    reset_n  = 1'b0;
    init_req = 1'b0;

    //  cyc init rst cke cmd bank addr    cv cd          done addr2   cd2
    add( 1, 0, 0, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add( 7, 0, 0, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add( 8, 0, 1, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(17, 0, 1, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(18, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(22, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(23, 0, 1, 1, MR, 2, 14'h008, 0, 32'h0,      0, 14'h010, 32'h0);
    add(24, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(26, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(27, 0, 1, 1, MR, 3, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(28, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(30, 1, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(31, 0, 1, 1, MR, 1, 14'h001, 0, 32'h0,      0, 14'h000, 32'h0);
    add(34, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(35, 0, 1, 1, MR, 0, 14'h420, 0, 32'h0,      0, 14'h540, 32'h0);
    add(36, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(40, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(41, 0, 1, 1, ZQ, 0, 14'h400, 0, 32'h0,      0, 14'h400, 32'h0);
    add(42, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(56, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(57, 0, 1, 1, NP, 0, 14'h000, 1, 32'h4400,   0, 14'h000, 32'h5600);
    add(58, 1, 1, 1, NP, 0, 14'h000, 0, 32'h0,      1, 14'h000, 32'h0);
    add(59, 0, 0, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(66, 0, 0, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(67, 0, 1, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(76, 0, 1, 0, DS, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(77, 0, 1, 1, NP, 0, 14'h000, 0, 32'h0,      0, 14'h000, 32'h0);
    add(82, 0, 1, 1, MR, 2, 14'h008, 0, 32'h0,      0, 14'h010, 32'h0);

    repeat (3) @(posedge clock);
    #1 chk_reset_vals("in_reset", 0);

    // Release between edges; cycle k = k-th edge after release.
    @(negedge clock) reset_n = 1'b1;
    ri = 0;
    pulses = 0;
    for (int cyc = 1; cyc <= 82; cyc++) begin
      @(posedge clock);
      #1;
      if (cv1) pulses++;
      init_req = 1'b0;
      if (ri < rows.size() && rows[ri].cyc == cyc) begin
        chk_row(rows[ri]);
        init_req = rows[ri].init;
        ri++;
      end
    end
    chk("rows_used", 82, 32'(ri), 32'(rows.size()));
    chk("cfg_pulses_first_run", 82, 32'(pulses), 32'd1);

    // Synchronous reset landing in the middle of ZQ calibration.
    init_req = 1'b0;
    @(negedge clock) reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == 41) chk("zq_before_reset", cyc, 32'({cs1, ras1, cas1, we1}), 32'(ZQ));
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1 chk_reset_vals("mid_zq", 46);
    reset_n = 1'b1;

    k = 0; seen = 0;
    while (!seen && k < 30) begin
      @(posedge clock);
      #1;
      k++;
      if (rst1) seen = 1;
    end
    chk("rerun_reset_n_rise", k, 32'(seen), 32'd1);
    chk("rerun_reset_n_cycle", k, 32'(k), 32'd8);

    pulses = 0; seen = 0;
    while (!seen && k < 200) begin
      @(posedge clock);
      #1;
      k++;
      if (cv1) pulses++;
      if (done1) seen = 1;
    end
    chk("rerun_done_seen", k, 32'(seen), 32'd1);
    chk("rerun_done_cycle", k, 32'(k), 32'd58);
    chk("rerun_cfg_pulses", k, 32'(pulses), 32'd1);
    chk("rerun_done2", k, 32'(done2), 32'd1);

    // Done state holds without a request.
    repeat (5) @(posedge clock);
    #1;
    chk("done_hold", k + 5, 32'(done1), 32'd1);
    chk("done_hold_cmd", k + 5, 32'({cs1, ras1, cas1, we1}), 32'(NP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
